// File: rtl/reel_blit_ctrl.sv
// Reel sprite blitter: streams a 64x64 sprite from a 2-cycle-latency ROM into the framebuffer,
// applying a vertical reel scroll, screen clipping and an optional transparent colour key.
module reel_blit_ctrl #(
  parameter bit          TRANSP_EN  = 1'b1,
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x_base,
  input  logic [6:0]  y_base,
  input  logic [5:0]  scroll,
  output logic [11:0] rom_address,
  input  logic [23:0] rom_q,
  output logic [7:0]  fb_x,
  output logic [6:0]  fb_y,
  output logic [23:0] fb_colour,
  output logic        fb_plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  drain_q, drain_d;
  logic        latch_en;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [5:0]  scroll_q;

  // Row/col tags ride alongside the ROM read so they meet rom_q in the same cycle.
  logic        v1_q, v2_q;
  logic [5:0]  r1_q, c1_q, r2_q, c2_q;

  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        plot_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_en = 1'b1;
          cnt_d    = 12'd0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'hFFF) begin
          drain_d = 2'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scroll wraps within the 64-row sprite; the column field is never carried into the row.
  always_comb begin
    rom_address = 12'd0;
    if (state_q == StFetch) rom_address = {6'(cnt_q[11:6] + scroll_q), cnt_q[5:0]};
  end

  assign busy = (state_q == StFetch) || (state_q == StDrain);
  assign done = (state_q == StDone);

  always_comb begin
    x_sum  = {1'b0, x_q} + {3'b000, c2_q};
    y_sum  = {1'b0, y_q} + {2'b00, r2_q};
    plot_d = v2_q && (x_sum < 9'd160) && (y_sum < 8'd120) &&
             !(TRANSP_EN && (rom_q == TRANSP_KEY));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 12'd0;
      drain_q   <= 2'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      scroll_q  <= 6'd0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      r1_q      <= 6'd0;
      c1_q      <= 6'd0;
      r2_q      <= 6'd0;
      c2_q      <= 6'd0;
      fb_plot   <= 1'b0;
      fb_x      <= 8'd0;
      fb_y      <= 7'd0;
      fb_colour <= 24'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      if (latch_en) begin
        x_q      <= x_base;
        y_q      <= y_base;
        scroll_q <= scroll;
      end
      v1_q    <= (state_q == StFetch);
      r1_q    <= cnt_q[11:6];
      c1_q    <= cnt_q[5:0];
      v2_q    <= v1_q;
      r2_q    <= r1_q;
      c2_q    <= c1_q;
      fb_plot <= plot_d;
      if (plot_d) begin
        fb_x      <= x_sum[7:0];
        fb_y      <= y_sum[6:0];
        fb_colour <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_reel_blit_ctrl.sv
// Directed bench for reel_blit_ctrl with a 2-cycle-latency ROM model and a per-cycle pixel model.
module tb_reel_blit_ctrl;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x_base;
  logic [6:0]  y_base;
  logic [5:0]  scroll;
  logic [11:0] rom_address;
  logic [23:0] rom_q, q1;
  logic [7:0]  fb_x;
  logic [6:0]  fb_y;
  logic [23:0] fb_colour;
  logic        fb_plot, busy, done;

  logic [23:0] mem [4096];

  int checks = 0;
  int errors = 0;

  reel_blit_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x_base      (x_base),
    .y_base      (y_base),
    .scroll      (scroll),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_colour   (fb_colour),
    .fb_plot     (fb_plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    q1    <= mem[rom_address];
    rom_q <= q1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one blit, comparing every cycle against the model; cycle c counts from the start edge.
  task automatic run_blit(input logic [7:0] xb, input logic [6:0] yb, input logic [5:0] sc,
                          input int ncyc, input bit pulses, input int rst_at,
                          output int plots, output int bad, output int done_cyc,
                          output int first_cyc, output logic [7:0] fx, output logic [6:0] fy,
                          output logic [23:0] fc, output logic [7:0] lx, output logic [6:0] ly,
                          output logic [23:0] lc, output int last_cyc,
                          output logic [11:0] addr0, output int imm_bad);
    bit          aborted, e_plot, e_busy, e_done;
    logic [11:0] e_addr, ka, a;
    logic [5:0]  r, cl;
    logic [23:0] col;
    logic [8:0]  xs;
    logic [7:0]  ys;
    logic [7:0]  px;
    logic [6:0]  py;
    logic [23:0] pc;
    plots = 0; bad = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1; imm_bad = 0;
    fx = 0; fy = 0; fc = 0; lx = 0; ly = 0; lc = 0; addr0 = 0;
    px = 0; py = 0; pc = 0; xs = 0; ys = 0; col = 0;
    @(negedge clock);
    x_base = xb; y_base = yb; scroll = sc; start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      aborted = (rst_at >= 0) && (c > rst_at);
      e_busy  = !aborted && (c <= 4098);
      e_done  = !aborted && (c == 4099);
      ka      = 12'(c);
      e_addr  = (!aborted && c <= 4095) ? {6'(ka[11:6] + sc), ka[5:0]} : 12'd0;
      e_plot  = 1'b0;
      if (!aborted && c >= 3 && c <= 4098) begin
        ka     = 12'(c - 3);
        r      = ka[11:6];
        cl     = ka[5:0];
        a      = {6'(r + sc), cl};
        col    = mem[a];
        xs     = {1'b0, xb} + {3'b000, cl};
        ys     = {1'b0, yb} + {2'b00, r};
        e_plot = (xs < 9'd160) && (ys < 8'd120) && (col != KEY);
      end
      if (fb_plot !== e_plot || busy !== e_busy || done !== e_done || rom_address !== e_addr)
        bad++;
      if (fb_plot === 1'b1) begin
        if (e_plot && (fb_x !== xs[7:0] || fb_y !== ys[6:0] || fb_colour !== col)) bad++;
        plots++;
        if (first_cyc < 0) begin
          first_cyc = c; fx = fb_x; fy = fb_y; fc = fb_colour;
        end
        last_cyc = c; lx = fb_x; ly = fb_y; lc = fb_colour;
      end else if (c > 0 && !(rst_at >= 0 && c > rst_at) &&
                   (fb_x !== px || fb_y !== py || fb_colour !== pc)) begin
        bad++;
      end
      px = fb_x; py = fb_y; pc = fb_colour;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 0) addr0 = rom_address;
      start = pulses && (c == 100 || c == 4099);
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        if (fb_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) imm_bad++;
      end
      if (c == rst_at + 1) reset = 1'b0;
    end
    start = 1'b0;
  endtask

  int plots, bad, done_cyc, first_cyc, last_cyc, imm_bad;
  logic [7:0]  fx, lx;
  logic [6:0]  fy, ly;
  logic [23:0] fc, lc;
  logic [11:0] addr0;

  initial begin
    for (int n = 0; n < 4096; n++) mem[n] = 24'(n);
    reset = 1'b1; start = 1'b0; x_base = 0; y_base = 0; scroll = 0;
    #12;
    chk("rst_fb_plot", fb_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_fb_xyc", {fb_x, fb_y, fb_colour}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Basic blit, identity ROM.
    run_blit(8'd10, 7'd20, 6'd0, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("basic_plots", plots, 4096);
    chk("basic_model", bad, 0);
    chk("basic_first_cyc", first_cyc, 3);
    chk("basic_first_px", {fx, fy, fc}, {8'd10, 7'd20, 24'd0});
    chk("basic_last_cyc", last_cyc, 4098);
    chk("basic_last_px", {lx, ly, lc}, {8'd73, 7'd83, 24'd4095});
    chk("basic_done_cyc", done_cyc, 4099);

    // Scroll wrap.
    run_blit(8'd0, 7'd0, 6'd5, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("scroll_addr0", addr0, 12'h140);
    chk("scroll_model", bad, 0);
    chk("scroll_first_px", {fx, fy, fc}, {8'd0, 7'd0, 24'h140});
    chk("scroll_plots", plots, 4096);

    // Clipping at right/bottom screen edges.
    run_blit(8'd150, 7'd100, 6'd0, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("clip_plots", plots, 200);
    chk("clip_model", bad, 0);
    chk("clip_last_px", {lx, ly}, {8'd159, 7'd119});
    chk("clip_done_cyc", done_cyc, 4099);

    // Transparent first sprite row.
    for (int n = 0; n < 64; n++) mem[n] = KEY;
    run_blit(8'd0, 7'd0, 6'd0, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("transp_plots", plots, 4032);
    chk("transp_model", bad, 0);
    chk("transp_first_cyc", first_cyc, 67);
    chk("transp_first_px", {fx, fy, fc}, {8'd0, 7'd1, 24'd64});
    for (int n = 0; n < 64; n++) mem[n] = 24'(n);

    // Start pulses while busy and in DONE are ignored; start right after DONE is taken.
    run_blit(8'd10, 7'd20, 6'd0, 4100, 1'b1, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("ign_model", bad, 0);
    chk("ign_done_cyc", done_cyc, 4099);
    run_blit(8'd10, 7'd20, 6'd3, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("b2b_model", bad, 0);
    chk("b2b_plots", plots, 4096);
    chk("b2b_done_cyc", done_cyc, 4099);

    // Mid-blit reset abort, then a full blit.
    run_blit(8'd10, 7'd20, 6'd0, 2300, 1'b0, 2000, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("abort_immediate", imm_bad, 0);
    chk("abort_model", bad, 0);
    chk("abort_plots", plots, 1998);
    chk("abort_no_done", done_cyc, -1);
    run_blit(8'd10, 7'd20, 6'd0, 4105, 1'b0, -1, plots, bad, done_cyc, first_cyc, fx, fy, fc,
             lx, ly, lc, last_cyc, addr0, imm_bad);
    chk("after_abort_model", bad, 0);
    chk("after_abort_plots", plots, 4096);
    chk("after_abort_done", done_cyc, 4099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
